// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared constants and helpers for the integrate-and-dump controller
package accum_pkg;

    localparam int ACCUM_DEFAULT_WIDTH = 16;

    // A window length of zero is treated as a single-sample window.
    function automatic logic [31:0] len_min1(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

    // Round-half-up right shift. The sum is held in 64 bits, which is wide enough
    // to carry the extra bit the bias can add to a WIDTH+1-bit value.
    function automatic logic [63:0] round_shift(input logic [63:0] v, input int unsigned sh);
        logic [63:0] bias;
        bias = (sh > 0) ? (64'd1 << (sh - 1)) : 64'd0;
        return (v + bias) >> sh;
    endfunction

endpackage

// File: rtl/accum_dump_outreg.sv
// rtl/accum_dump_outreg.sv - valid/ready output holding register with sticky overrun
module accum_dump_outreg #(
    parameter int DW = 17
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_cap,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    input  logic          i_ovr_clr,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_overrun
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_overrun;
    logic          w_lost;

    // A capture only loses data when the held value has not been taken this cycle.
    assign w_lost = i_cap && r_valid && !i_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (i_cap) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end

            if (w_lost) begin
                r_overrun <= 1'b1;
            end else if (i_ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/accum_dump.sv
// rtl/accum_dump.sv - integrate-and-dump controller; ACCUM_DUMP_SHIFT_EN enables rounded output scaling
module accum_dump
    import accum_pkg::*;
#(
    parameter int WIDTH = ACCUM_DEFAULT_WIDTH,
    parameter int CNT_W = 8,
    parameter int SHIFT = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [WIDTH:0]   in_q,
    input  logic [CNT_W-1:0] dump_len,
    output logic             clr_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_data,
    output logic             overrun,
    input  logic             overrun_clr
);

`ifdef ACCUM_DUMP_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif
    localparam int unsigned SHIFT_AMT = SHIFT_EN ? SHIFT : 0;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len_q;
    logic             r_cap_pend;

    logic             w_active;
    logic             w_start;
    logic             w_terminal;
    logic [CNT_W-1:0] w_len_new;
    logic [CNT_W-1:0] w_len_cur;
    logic [WIDTH:0]   w_cap_data;

    assign w_active  = enable && in_valid;
    assign w_start   = w_active && (r_cnt == '0);
    assign w_len_new = CNT_W'(len_min1(32'(dump_len)));
    // The first sample of a window must see the freshly latched length so that
    // single-sample windows terminate on the same sample that starts them.
    assign w_len_cur  = w_start ? w_len_new : r_len_q;
    assign w_terminal = w_active && (r_cnt == (w_len_cur - CNT_W'(1)));
    assign clr_out    = w_start;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_len_q    <= CNT_W'(1);
            r_cap_pend <= 1'b0;
        end else begin
            if (!enable) begin
                r_cnt <= '0;
            end else if (in_valid) begin
                r_cnt <= w_terminal ? '0 : (r_cnt + CNT_W'(1));
            end
            if (w_start) begin
                r_len_q <= w_len_new;
            end
            r_cap_pend <= w_terminal;
        end
    end

    assign w_cap_data = (WIDTH + 1)'(round_shift(64'(in_q), SHIFT_AMT));

    accum_dump_outreg #(
        .DW (WIDTH + 1)
    ) u_outreg (
        .clock     (clock),
        .reset     (reset),
        .i_cap     (r_cap_pend),
        .i_data    (w_cap_data),
        .i_ready   (out_ready),
        .i_ovr_clr (overrun_clr),
        .o_valid   (out_valid),
        .o_data    (out_data),
        .o_overrun (overrun)
    );

endmodule

// File: tb/tb_accum_dump.sv
// tb/tb_accum_dump.sv - scoreboard bench for accum_dump with a behavioural accumulator
module tb_accum_dump;

    localparam int W  = 16;
    localparam int CW = 8;
    localparam int SH = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          in_valid;
    logic [W:0]    in_q;
    logic [CW-1:0] dump_len;
    logic          clr_out;
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    out_data;
    logic          overrun;
    logic          overrun_clr;

    int            total = 0;
    int            bad   = 0;
    logic [W:0]    exp_q[$];
    int            mcnt  = 0;
    int            mlen  = 1;
    logic [W:0]    msum  = '0;
    logic [W:0]    d_val = 17'd10000;

    always #5 clock = ~clock;

    accum_dump #(
        .WIDTH (W),
        .CNT_W (CW),
        .SHIFT (SH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_q        (in_q),
        .dump_len    (dump_len),
        .clr_out     (clr_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    // Accumulator with load-on-clr semantics and one cycle of latency.
    always @(posedge clock) begin
        if (reset) in_q <= '0;
        else if (in_valid) in_q <= clr_out ? d_val : (in_q + d_val);
    end

    function automatic logic [W:0] expv(input logic [W:0] s);
`ifdef ACCUM_DUMP_SHIFT_EN
        logic [W+1:0] t;
        t = {1'b0, s} + (W + 2)'(1 << (SH - 1));
        return (W + 1)'(t >> SH);
`else
        return s;
`endif
    endfunction

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got %0d want none", out_data);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    bad++;
                    $display("FAIL out_data: got %0d want %0d", out_data, e);
                end
            end
        end
    end

    task automatic sample(input logic v, input logic en);
        @(posedge clock);
        #1;
        in_valid = v;
        enable   = en;
        #1;
        total++;
        if (v && en) begin
            if (clr_out !== 1'(mcnt == 0)) begin
                bad++;
                $display("FAIL clr_out: got %b want %b", clr_out, (mcnt == 0));
            end
            if (mcnt == 0) begin
                mlen = (dump_len == 0) ? 1 : int'(dump_len);
                msum = d_val;
            end else begin
                msum = msum + d_val;
            end
            if (mcnt == mlen - 1) begin
                exp_q.push_back(expv(msum));
                mcnt = 0;
            end else begin
                mcnt++;
            end
        end else begin
            if (!en) mcnt = 0;
            if (clr_out !== 1'b0) begin
                bad++;
                $display("FAIL clr_out_idle: got %b want 0", clr_out);
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
        @(negedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        overrun_clr = 1'b0; dump_len = 8'd4;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        if (clr_out !== 1'b0) begin bad++; $display("FAIL rst_clr: got %b want 0", clr_out); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        if (out_data !== '0) begin bad++; $display("FAIL rst_data: got %0d want 0", out_data); end
    endtask

    task automatic test_basic();
        dump_len = 8'd4; out_ready = 1'b1; d_val = 17'd10000;
        for (int i = 0; i < 12; i++) sample(1'b1, 1'b1);
        sample(1'b0, 1'b1);
        sample(1'b0, 1'b1);
        wait_drain();
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL basic_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_overrun();
        dump_len = 8'd2; out_ready = 1'b0;
        sample(1'b1, 1'b1); sample(1'b1, 1'b1); sample(1'b0, 1'b1); sample(1'b0, 1'b1);
        @(negedge clock);
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid1: got %b want 1", out_valid); end
        if (out_data !== exp_q[0]) begin bad++; $display("FAIL ovr_data1: got %0d want %0d", out_data, exp_q[0]); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_flag1: got %b want 0", overrun); end
        sample(1'b1, 1'b1); sample(1'b1, 1'b1); sample(1'b0, 1'b1); sample(1'b0, 1'b1);
        @(negedge clock);
        total += 2;
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag2: got %b want 1", overrun); end
        if (out_data !== exp_q[$]) begin bad++; $display("FAIL ovr_data2: got %0d want %0d", out_data, exp_q[$]); end
        void'(exp_q.pop_front());
        @(posedge clock); #1 overrun_clr = 1'b1;
        @(posedge clock); #1 overrun_clr = 1'b0;
        @(negedge clock);
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr: got %b want 1'b0", overrun); end
        // Clear coincides with a fresh overrun event: the set must win.
        sample(1'b1, 1'b1); sample(1'b1, 1'b1);
        @(posedge clock); #1 in_valid = 1'b0; overrun_clr = 1'b1;
        @(posedge clock); #1 overrun_clr = 1'b0;
        @(negedge clock);
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
        void'(exp_q.pop_front());
        @(posedge clock); #1 overrun_clr = 1'b1;
        @(posedge clock); #1 overrun_clr = 1'b0; out_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        dump_len = 8'd2; out_ready = 1'b0; d_val = 17'd7000;
        sample(1'b1, 1'b1); sample(1'b1, 1'b1); sample(1'b0, 1'b1); sample(1'b0, 1'b1);
        d_val = 17'd9000;
        sample(1'b1, 1'b1); sample(1'b1, 1'b1);
        @(posedge clock); #1 in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1 out_ready = 1'b0;
        @(negedge clock);
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
        if (out_data !== exp_q[0]) begin bad++; $display("FAIL b2b_data: got %0d want %0d", out_data, exp_q[0]); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        out_ready = 1'b1;
        wait_drain();
        d_val = 17'd10000;
    endtask

    task automatic test_len();
        out_ready = 1'b1; dump_len = 8'd0;
        for (int i = 0; i < 3; i++) sample(1'b1, 1'b1);
        sample(1'b0, 1'b1); sample(1'b0, 1'b1);
        wait_drain();
        dump_len = 8'd4;
        sample(1'b1, 1'b1); sample(1'b1, 1'b1);
        dump_len = 8'd2;
        for (int i = 0; i < 4; i++) sample(1'b1, 1'b1);
        sample(1'b0, 1'b0); sample(1'b0, 1'b1);
        wait_drain();
    endtask

    task automatic test_enable();
        out_ready = 1'b1; dump_len = 8'd4;
        sample(1'b1, 1'b1); sample(1'b1, 1'b1);
        sample(1'b1, 1'b0);
        sample(1'b0, 1'b0); sample(1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL en_discard: got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) sample(1'b1, 1'b1);
        sample(1'b0, 1'b1); sample(1'b0, 1'b1);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; dump_len = 8'd2;
        for (int i = 0; i < 4; i++) sample(1'b1, 1'b1);
        sample(1'b0, 1'b1); sample(1'b0, 1'b1);
        sample(1'b1, 1'b1);
        @(posedge clock);
        #3 reset = 1'b1; in_valid = 1'b0;
        #1;
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        if (out_data !== '0) begin bad++; $display("FAIL mid_rst_data: got %0d want 0", out_data); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL mid_rst_overrun: got %b want 0", overrun); end
        if (clr_out !== 1'b0) begin bad++; $display("FAIL mid_rst_clr: got %b want 0", clr_out); end
        exp_q.delete();
        mcnt = 0;
        @(posedge clock); #1 reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) sample(1'b0, 1'b1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_release: got %b want 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_len();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
